sub_nibble_serial: RTL and testbench

- Multi-cycle 32-bit subtract/compare unit for the NPC execute stage. It handles SUB, SLT and SLTU, which are the inverse direction of the 4-bit lookahead adder used on the add path.
- Computes a - b as a + ~b + 1, one 4-bit lookahead-borrow nibble per clock, LSB nibble first.
- Operands are taken through a valid/ready input handshake. The result is presented through a valid/ready output handshake and includes borrow, overflow and zero flags for branch resolution.

---
 rtl/sub_nibble_serial.sv | 229 ++++++++++++++++++++++
 tb/tb_sub_nibble_serial.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_nibble_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sub_nibble_serial                                          |
// | Description : Multi-cycle subtract/compare unit (SUB, SLT, SLTU).        |
// |               Computes a + ~b + 1 one 4-bit lookahead nibble per clock,  |
// |               LSB nibble first, with valid/ready on both sides and       |
// |               borrow/overflow/zero flags for branch resolution.          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module sub_nibble_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_borrow,
  output logic             out_overflow,
  output logic             out_zero
);

  // WIDTH is expected to be a multiple of 4; NIB nibble steps per operation.
  localparam int            NIB      = WIDTH / 4;
  localparam int            CW       = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);
  localparam logic [1:0]    OP_SLT   = 2'd1;
  localparam logic [1:0]    OP_SLTU  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Control state
  state_t          state_q,     state_d;
  logic            in_ready_q,  in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic            carry_q,     carry_d;

  // Operand shift registers: the nibble being processed always sits in [3:0],
  // so no variable part-select is needed on the datapath.
  logic [WIDTH-1:0] a_q,    a_d;
  logic [WIDTH-1:0] nb_q,   nb_d;
  logic [1:0]       op_q,   op_d;
  logic [WIDTH-1:0] diff_q, diff_d;

  // Registered results
  logic [WIDTH-1:0] res_q,    res_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q,    ovf_d;
  logic             zero_q,   zero_d;

  // Nibble datapath wires
  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_nb;
  logic [3:0]       w_nib_g;
  logic [3:0]       w_nib_p;
  logic [3:0]       w_nib_c;
  logic             w_nib_c4;
  logic [3:0]       w_nib_diff;
  logic [WIDTH+3:0] w_diff_cat;
  logic [WIDTH-1:0] w_diff_next;
  logic             w_a_msb;
  logic             w_b_msb;
  logic             w_brw;
  logic             w_ovf;
  logic             w_zero;

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_result   = res_q;
  assign out_borrow   = borrow_q;
  assign out_overflow = ovf_q;
  assign out_zero     = zero_q;

  // Four-bit carry-lookahead on the current nibble of a and ~b.
  always_comb begin
    w_nib_a    = a_q[3:0];
    w_nib_nb   = nb_q[3:0];
    w_nib_g    = w_nib_a & w_nib_nb;
    w_nib_p    = w_nib_a ^ w_nib_nb;
    w_nib_c[0] = carry_q;
    w_nib_c[1] = w_nib_g[0]
               | (w_nib_p[0] & carry_q);
    w_nib_c[2] = w_nib_g[1]
               | (w_nib_p[1] & w_nib_g[0])
               | (w_nib_p[1] & w_nib_p[0] & carry_q);
    w_nib_c[3] = w_nib_g[2]
               | (w_nib_p[2] & w_nib_g[1])
               | (w_nib_p[2] & w_nib_p[1] & w_nib_g[0])
               | (w_nib_p[2] & w_nib_p[1] & w_nib_p[0] & carry_q);
    w_nib_c4   = w_nib_g[3]
               | (w_nib_p[3] & w_nib_g[2])
               | (w_nib_p[3] & w_nib_p[2] & w_nib_g[1])
               | (w_nib_p[3] & w_nib_p[2] & w_nib_p[1] & w_nib_g[0])
               | (w_nib_p[3] & w_nib_p[2] & w_nib_p[1] & w_nib_p[0] & carry_q);
    w_nib_diff = w_nib_p ^ w_nib_c;
  end

  // Difference assembly (new nibble enters at the top) and final flags; the
  // flags are only consumed on the last nibble, when a_q[3]/nb_q[3] hold the MSBs.
  always_comb begin
    w_diff_cat  = {w_nib_diff, diff_q};
    w_diff_next = w_diff_cat[WIDTH+3:4];
    w_a_msb     = a_q[3];
    w_b_msb     = ~nb_q[3];
    w_brw       = ~w_nib_c4;
    w_ovf       = (w_a_msb != w_b_msb) && (w_diff_next[WIDTH-1] != w_a_msb);
    w_zero      = ~|w_diff_next;
  end

  // Next-state and datapath update logic for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    nb_d        = nb_q;
    op_d        = op_q;
    diff_d      = diff_q;
    res_d       = res_q;
    borrow_d    = borrow_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;

    case (state_q)
      S_IDLE: begin
        // in_ready rises on the first edge out of reset and stays up here.
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_d        = in_a;
          nb_d       = ~in_b;
          op_d       = in_op;
          carry_d    = 1'b1;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        a_d     = a_q >> 4;
        nb_d    = nb_q >> 4;
        diff_d  = w_diff_next;
        carry_d = w_nib_c4;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_NIB) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          borrow_d    = w_brw;
          ovf_d       = w_ovf;
          zero_d      = w_zero;
          case (op_q)
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, w_diff_next[WIDTH-1] ^ w_ovf};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, w_brw};
            default: res_d = w_diff_next;
          endcase
        end
      end

      S_DONE: begin
        // Results are held until the consumer takes them.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake, counter and datapath registers; reset discards any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      nb_q        <= '0;
      op_q        <= 2'd0;
      diff_q      <= '0;
      res_q       <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      nb_q        <= nb_d;
      op_q        <= op_d;
      diff_q      <= diff_d;
      res_q       <= res_d;
      borrow_q    <= borrow_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sub_nibble_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sub_nibble_serial                                       |
// | Description : Scoreboard testbench for sub_nibble_serial (WIDTH=32).     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_sub_nibble_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [1:0]  in_op = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_borrow;
  logic        out_overflow;
  logic        out_zero;

  typedef struct packed {
    logic [31:0] res;
    logic        brw;
    logic        ovf;
    logic        zro;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  sub_nibble_serial #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_op        (in_op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_borrow   (out_borrow),
    .out_overflow (out_overflow),
    .out_zero     (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model using plain arithmetic and signed/unsigned compares.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    exp_t        e;
    logic [31:0] d;
    d     = a - b;
    e.brw = (a < b);
    e.ovf = (a[31] != b[31]) && (d[31] != a[31]);
    e.zro = (d == 32'd0);
    case (op)
      2'd1:    e.res = {31'b0, ($signed(a) < $signed(b))};
      2'd2:    e.res = {31'b0, e.brw};
      default: e.res = d;
    endcase
    return e;
  endfunction

  // Present operands at a negedge and return at the negedge after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_valid = 1'b1;
    sb.push_back(model(a, b, op));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_op    = 2'($urandom_range(0, 3));
    chk("ready_drop", 32'(in_ready), 32'd0);
  endtask

  // Wait for the result, compare, optionally stall, then complete the handshake.
  task automatic recv(input int stall, input bit poke);
    int          cyc;
    exp_t        e;
    logic [31:0] r0;
    logic        b0, o0, z0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd8);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (!out_valid) return;
    chk("result", out_result, e.res);
    chk("borrow", 32'(out_borrow), 32'(e.brw));
    chk("overflow", 32'(out_overflow), 32'(e.ovf));
    chk("zero", 32'(out_zero), 32'(e.zro));
    chk("busy_ready", 32'(in_ready), 32'd0);
    r0 = out_result;
    b0 = out_borrow;
    o0 = out_overflow;
    z0 = out_zero;
    for (int i = 0; i < stall; i++) begin
      if (poke && i == 2) begin
        in_valid = 1'b1;
        in_a     = 32'h0BAD_F00D;
        in_b     = 32'h1234_0000;
        in_op    = 2'd0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", out_result, r0);
      chk("hold_flags", {29'b0, out_borrow, out_overflow, out_zero}, {29'b0, b0, o0, z0});
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    send(a, b, op);
    recv(0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", {29'b0, out_borrow, out_overflow, out_zero}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rel_in_ready_high", 32'(in_ready), 32'd1);

    // Directed operations
    run_op(32'd5, 32'd3, 2'd0);
    run_op(32'd0, 32'd1, 2'd0);
    run_op(32'd0, 32'd1, 2'd2);
    run_op(32'd0, 32'd1, 2'd1);
    run_op(32'h8000_0000, 32'd1, 2'd0);
    run_op(32'h8000_0000, 32'd1, 2'd1);
    run_op(32'h8000_0000, 32'd1, 2'd2);
    run_op(32'h1234_5678, 32'h1234_5678, 2'd0);
    run_op(32'h0001_0000, 32'h0000_FFFF, 2'd0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'd3);
    run_op(32'hFFFF_FFFF, 32'd1, 2'd1);
    run_op(32'd1, 32'hFFFF_FFFF, 2'd2);

    // Backpressure with an ignored in_valid pulse, then a new op
    out_ready = 1'b0;
    send(32'hDEAD_BEEF, 32'h0000_BEEF, 2'd0);
    recv(5, 1'b1);
    run_op(32'hFFFF_FFFF, 32'd1, 2'd1);

    // Random operations
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i == 3) ? ra : $urandom;
      run_op(ra, rb, 2'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of RUN
    send(32'h1111_2222, 32'h0303_0404, 2'd0);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_result", out_result, 32'd0);
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_valid", 32'(out_valid), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("rel2_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rel2_in_ready_high", 32'(in_ready), 32'd1);
    chk("rel2_out_valid", 32'(out_valid), 32'd0);
    run_op(32'd10, 32'd7, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
